// File: rtl/seg_sched_pkg.sv
// Shared types and helpers for the seven-segment display-source scheduler.
package seg_sched_pkg;

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } state_t;

   localparam logic [1:0] SRC_ODATA = 2'd0;
   localparam logic [1:0] SRC_PC    = 2'd1;
   localparam logic [1:0] SRC_INST  = 2'd2;

   // Rotation order 0 -> 1 -> 2 -> 0; code 3 folds back to the start.
   function automatic logic [1:0] next_src(input logic [1:0] s);
      case (s)
         SRC_ODATA: return SRC_PC;
         SRC_PC:    return SRC_INST;
         default:   return SRC_ODATA;
      endcase
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_source_sched_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, optional stability filter, clean level
// and single-cycle press pulse on the clean rising edge.
module btn_debounce
   import seg_sched_pkg::*;
#(
   parameter bit DEBOUNCE_EN     = 1'b1,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   logic [1:0] sync_q;
   logic       clean;
   logic       level_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], btn};
   end

   generate
      if (DEBOUNCE_EN) begin : g_db
         localparam int CW = cnt_w(DEBOUNCE_CYCLES);
         localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
         logic [CW-1:0] cnt_q;
         logic          clean_q;

         // The clean level only follows the synchronized input after it has
         // disagreed for DEBOUNCE_CYCLES consecutive cycles.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_q   <= '0;
               clean_q <= 1'b0;
            end else if (sync_q[1] == clean_q) begin
               cnt_q   <= '0;
            end else if (cnt_q == TERM) begin
               cnt_q   <= '0;
               clean_q <= sync_q[1];
            end else begin
               cnt_q   <= cnt_q + 1'b1;
            end
         end
         assign clean = clean_q;
      end else begin : g_bypass
         assign clean = sync_q[1];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) level_q <= 1'b0;
      else        level_q <= clean;
   end

   assign level = clean;
   assign press = clean & ~level_q;

endmodule

// File: rtl/seg_source_sched.sv
// Time-shares the 32-bit seven-segment data path among CPU result, PC and
// instruction. Define SEG_SCHED_DEBOUNCE_EN to filter the advance button.
module seg_source_sched
   import seg_sched_pkg::*;
#(
   parameter int DWELL_CYCLES    = 100_000_000,
   parameter int GAP_CYCLES      = 5_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] src_odata,
   input  logic [31:0] src_pc,
   input  logic [31:0] src_inst,
   input  logic        auto_en,
   input  logic        freeze,
   input  logic        btn_next,
   output logic [31:0] o_data,
   output logic        o_en,
   output logic [1:0]  o_src
);

   localparam int DW = cnt_w(DWELL_CYCLES);
   localparam int GW = cnt_w(GAP_CYCLES);
   localparam logic [DW-1:0] DWELL_TERM = DW'(DWELL_CYCLES - 1);
   localparam logic [GW-1:0] GAP_TERM   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SEG_SCHED_DEBOUNCE_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif

   state_t        state_q, state_n;
   logic [1:0]    cur_src_q, src_n;
   logic [DW-1:0] dwell_q, dwell_n;
   logic [GW-1:0] gap_q, gap_n;
   logic          press, btn_level, dwell_hit, advance;
   logic [31:0]   data_n;
   logic          en_n;

   btn_debounce #(
      .DEBOUNCE_EN     (DB_EN),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_next),
      .level (btn_level),
      .press (press)
   );

   assign dwell_hit = auto_en && !freeze && (dwell_q == DWELL_TERM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= SHOW;
         cur_src_q <= SRC_ODATA;
         dwell_q   <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_n;
         cur_src_q <= src_n;
         dwell_q   <= dwell_n;
         gap_q     <= gap_n;
      end
   end

   // Dwell expiry and a press in the same cycle collapse into one advance.
   always_comb begin
      state_n = state_q;
      src_n   = cur_src_q;
      dwell_n = dwell_q;
      gap_n   = gap_q;
      advance = 1'b0;
      case (state_q)
         SHOW: begin
            advance = dwell_hit || press;
            if (advance) begin
               dwell_n = '0;
               gap_n   = '0;
               src_n   = next_src(cur_src_q);
               if (GAP_CYCLES > 0) state_n = BLANK;
            end else if (!auto_en) begin
               dwell_n = '0;
            end else if (!freeze) begin
               dwell_n = dwell_q + 1'b1;
            end
         end
         BLANK: begin
            if (gap_q == GAP_TERM) begin
               gap_n   = '0;
               state_n = SHOW;
            end else begin
               gap_n   = gap_q + 1'b1;
            end
         end
         default: state_n = SHOW;
      endcase
   end

   // Outputs are computed from the next state so the new source is shown on
   // the same edge the blanking gap ends.
   always_comb begin
      en_n   = (state_n == SHOW);
      data_n = o_data;
      if (en_n && !freeze) begin
         case (src_n)
            SRC_PC:   data_n = src_pc;
            SRC_INST: data_n = src_inst;
            default:  data_n = src_odata;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_data <= '0;
         o_en   <= 1'b0;
         o_src  <= SRC_ODATA;
      end else begin
         o_data <= data_n;
         o_en   <= en_n;
         o_src  <= src_n;
      end
   end

endmodule

// File: tb/tb_seg_source_sched.sv
// Directed bench for seg_source_sched with DWELL=8, GAP=2, DEBOUNCE=4.
module tb_seg_source_sched;

   localparam logic [31:0] W_O = 32'h11111111;
   localparam logic [31:0] W_P = 32'h00400000;
   localparam logic [31:0] W_I = 32'h2008000A;
`ifdef SEG_SCHED_DEBOUNCE_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] src_odata, src_pc, src_inst;
   logic        auto_en, freeze, btn_next;
   logic [31:0] o_data;
   logic        o_en;
   logic [1:0]  o_src;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        auto_en;
      logic        en;
      logic [1:0]  src;
      logic [31:0] data;
   } vec_t;
   vec_t tbl[$];

   seg_source_sched #(
      .DWELL_CYCLES    (8),
      .GAP_CYCLES      (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src_odata (src_odata),
      .src_pc    (src_pc),
      .src_inst  (src_inst),
      .auto_en   (auto_en),
      .freeze    (freeze),
      .btn_next  (btn_next),
      .o_data    (o_data),
      .o_en      (o_en),
      .o_src     (o_src)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input int n, input logic a, input logic en,
                          input logic [1:0] src, input logic [31:0] data);
      vec_t v;
      v.auto_en = a; v.en = en; v.src = src; v.data = data;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench just after a negedge with reset released; next posedge is edge 1.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; btn_next = 1'b0; freeze = 1'b0; auto_en = 1'b1;
      src_odata = W_O;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Auto rotation with a 10-cycle press whose raw edge precedes edge raw_on.
   // Either way only the dwell advance at edge 8 may be visible up to edge 17.
   task automatic seq_check(input int raw_on, input string tag);
      logic        e_en;
      logic [1:0]  e_src;
      logic [31:0] e_data;
      do_reset();
      for (int e = 1; e <= 17; e++) begin
         btn_next = (e >= raw_on) && (e < raw_on + 10);
         tick();
         if (e <= 7)      begin e_en = 1'b1; e_src = 2'd0; e_data = W_O; end
         else if (e <= 9) begin e_en = 1'b0; e_src = 2'd1; e_data = W_O; end
         else             begin e_en = 1'b1; e_src = 2'd1; e_data = W_P; end
         chk({tag, "_en"},   {31'd0, o_en}, {31'd0, e_en});
         chk({tag, "_src"},  {30'd0, o_src}, {30'd0, e_src});
         chk({tag, "_data"}, o_data, e_data);
      end
      btn_next = 1'b0;
   endtask

   initial begin
      int n;
      logic bounce [18];
      reset = 1'b0; auto_en = 1'b1; freeze = 1'b0; btn_next = 1'b0;
      src_odata = W_O; src_pc = W_P; src_inst = W_I;

      // Edges after release: 7 of src0, 2 blank, 8 per source, 2 blank, ...
      add_vec(7, 1'b1, 1'b1, 2'd0, W_O);
      add_vec(2, 1'b1, 1'b0, 2'd1, W_O);
      add_vec(8, 1'b1, 1'b1, 2'd1, W_P);
      add_vec(2, 1'b1, 1'b0, 2'd2, W_P);
      add_vec(8, 1'b1, 1'b1, 2'd2, W_I);
      add_vec(2, 1'b1, 1'b0, 2'd0, W_I);
      add_vec(1, 1'b1, 1'b1, 2'd0, W_O);

      @(negedge clk);
      @(negedge clk);
      chk("reset_en",   {31'd0, o_en}, 32'd0);
      chk("reset_src",  {30'd0, o_src}, 32'd0);
      chk("reset_data", o_data, 32'd0);
      reset = 1'b1;

      foreach (tbl[i]) begin
         auto_en = tbl[i].auto_en;
         tick();
         chk($sformatf("tbl%0d_en", i),   {31'd0, o_en}, {31'd0, tbl[i].en});
         chk($sformatf("tbl%0d_src", i),  {30'd0, o_src}, {30'd0, tbl[i].src});
         chk($sformatf("tbl%0d_data", i), o_data, tbl[i].data);
         if (o_src == 2'd3) chk("src_never_3", {30'd0, o_src}, 32'd0);
      end

      // Manual mode: idle, then a clean press, then bounce.
      auto_en = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("manual_idle_src", {30'd0, o_src}, 32'd0);
      end
      chk("manual_idle_en", {31'd0, o_en}, 32'd1);
      chk("manual_idle_data", o_data, W_O);

      btn_next = 1'b1;
      n = 0;
      while (n < 20 && o_src == 2'd0) begin
         tick();
         n++;
      end
      chk("press_latency", n, LAT);
      for (int i = n; i < 10; i++) tick();
      btn_next = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("press_once_src", {30'd0, o_src}, 32'd1);
      chk("press_once_en",  {31'd0, o_en}, 32'd1);
      chk("press_once_data", o_data, W_P);

`ifdef SEG_SCHED_DEBOUNCE_EN
      bounce = '{1,0,0,0,1,1,0,0,0,1,0,0,0,1,1,0,0,0};
      foreach (bounce[i]) begin
         btn_next = bounce[i];
         tick();
      end
      btn_next = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("bounce_src", {30'd0, o_src}, 32'd1);
`endif

      // Press pulse landing on the dwell-expiry edge, then one landing in BLANK.
      seq_check(8 - LAT + 1, "coincide");
      seq_check(9 - LAT + 1, "blank_press");

      // Freeze holds the word and the dwell count.
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      freeze = 1'b1;
      src_odata = 32'hDEADBEEF;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("freeze_data", o_data, W_O);
         chk("freeze_src", {30'd0, o_src}, 32'd0);
      end
      freeze = 1'b0;
      tick();
      chk("unfreeze_data", o_data, 32'hDEADBEEF);
      chk("unfreeze_en", {31'd0, o_en}, 32'd1);
      src_odata = W_O;

      // Asynchronous reset in the middle of a blanking gap.
      do_reset();
      for (int i = 0; i < 8; i++) tick();
      chk("pre_reset_en", {31'd0, o_en}, 32'd0);
      chk("pre_reset_src", {30'd0, o_src}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("async_reset_en",   {31'd0, o_en}, 32'd0);
      chk("async_reset_src",  {30'd0, o_src}, 32'd0);
      chk("async_reset_data", o_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("restart_en",   {31'd0, o_en}, 32'd1);
      chk("restart_src",  {30'd0, o_src}, 32'd0);
      chk("restart_data", o_data, W_O);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_source_sched.md
# seg_source_sched

Display-source scheduler between the pipelined CPU and the 8-digit seven-segment driver. It time-shares the single 32-bit display path among three CPU debug words: result data, PC and current instruction. Sources rotate automatically on a dwell timer or advance manually on a debounced push-button, with a blanking gap between sources. It drives the data word and enable of the `seg7x16` driver in place of a hard-wired enable and data.

## Interface
- `DWELL_CYCLES`, 100_000_000: clk cycles each source is shown in auto mode (≥2)
- `GAP_CYCLES`, 5_000_000: clk cycles of blanking between sources (0 = no gap)
- `DEBOUNCE_CYCLES`, 1_000_000: cycles the synchronized button must be stable (≥1)
- `clk` in 1: system clock, the undivided board clock
- `reset` in 1: asynchronous, active-low reset
- `src_odata` in 32: CPU result word
- `src_pc` in 32: CPU program counter
- `src_inst` in 32: CPU current instruction
- `auto_en` in 1: 1 = timed rotation, 0 = manual-only
- `freeze` in 1: hold displayed word and dwell count
- `btn_next` in 1: raw, asynchronous push-button
- `o_data` out 32: word to display driver
- `o_en` out 1: display enable, 0 while blanking
- `o_src` out 2: source shown, 0 = odata, 1 = pc, 2 = inst

## Operation
- FSM states: SHOW, BLANK. Register `cur_src` holds the source. Order is 0→1→2→0; code 3 is never produced.
- Reset values: state SHOW, `cur_src` 0, dwell and gap counters 0, `o_data` 0, `o_en` 0, `o_src` 0.
- SHOW:
  - `o_en`=1.
  - `o_data` is loaded every cycle from the selected source unless `freeze`=1.
  - The dwell counter increments when `auto_en`=1 and `freeze`=0.
- Advance event: dwell counter == DWELL_CYCLES−1, or a debounced button press, or both in the same cycle. Simultaneous events count as one advance.
- Advance behaviour:
  - Clear the dwell counter.
  - Set `cur_src` to the next source.
  - If GAP_CYCLES>0, enter BLANK. If GAP_CYCLES=0, stay in SHOW with the new source.
- BLANK:
  - `o_en`=0 and `o_data` holds.
  - Lasts exactly GAP_CYCLES cycles, then returns to SHOW.
  - Button presses in BLANK are discarded.
- `auto_en` 1→0: the dwell counter clears and the current source is kept. `auto_en` 0→1: counting restarts from 0.
- `freeze` does not block a button advance. After the advance, `o_data` keeps the old word until `freeze` drops. `o_src` still updates.
- Button path: 2-FF synchronizer, then debounce, then rising-edge detect. One press yields exactly one advance pulse. Holding the button does not auto-repeat.
- Counter widths are `$clog2` of their parameter, with a minimum of 1. Counters never wrap past terminal.

## Timing
- All outputs are registered.
- A source word change appears on `o_data` 1 cycle later.
- Dwell expiry: the last SHOW cycle is counter = DWELL_CYCLES−1. `o_en` falls on the next edge. `o_en` rises GAP_CYCLES cycles after that, with the new `o_src` and `o_data`.
- `o_src` changes on the same edge `o_en` falls.
- Button latency: raw edge → advance within 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Asserting `reset` mid-BLANK or mid-debounce returns immediately (asynchronously) to reset values. First SHOW display is on the first edge after release.

## Configuration
- `SEG_SCHED_DEBOUNCE_EN` defined: debounce stage instantiated per DEBOUNCE_CYCLES.
- Not defined: debounce bypassed. The synchronized button feeds the edge detect directly, so latency is 3 cycles, and DEBOUNCE_CYCLES is ignored.

## Structure
- `seg_sched_pkg`: state enum (SHOW, BLANK) and source codes (SRC_ODATA=0, SRC_PC=1, SRC_INST=2).
- Sub-module `btn_debounce`: synchronizer, stability counter, clean level and press pulse. Reusable for other board buttons.

## Test plan
Bench parameters: DWELL=8, GAP=2, DEBOUNCE=4, debounce macro on. Sources fixed at odata=32'h11111111, pc=32'h00400000, inst=32'h2008000A.
- Reset release with `auto_en`=1:
  - `o_en`=1, `o_data`=32'h11111111 and `o_src`=0 on the first edge.
  - After 8 cycles, `o_en`=0 for 2 cycles, then `o_data`=32'h00400000 and `o_src`=1.
- Full rotation: 3 advances return `o_src` to 0. `o_src` never equals 3.
- Manual mode:
  - `auto_en`=0 and 100 idle cycles: no change.
  - Clean 10-cycle press: exactly one advance, within 7 cycles.
  - Bounce pulses of 1–2 cycles: no advance.
- Press in the same cycle as dwell expiry gives a single advance, to `o_src`=1. A press during BLANK is ignored.
- `freeze`=1 in SHOW with `src_odata` changed to 32'hDEADBEEF:
  - `o_data` holds 32'h11111111 and no dwell advance occurs.
  - After release, 32'hDEADBEEF appears 1 cycle later.
- Assert `reset` mid-BLANK: all outputs go to 0 immediately. Sequence restarts at `o_src`=0.
